// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift engine: shift codes,
// sequencer state encoding and default widths.
package shift_pkg;

    localparam int DFLT_WIDTH = 16;
    localparam int DFLT_AMT_W = 4;

    // Shift codes, identical to the single-step datapath shifter
    localparam logic [1:0] SH_PASS = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_RS1  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shifter. Each output bit selects its source
// neighbour by shift code; edge bits take the fill value instead.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = shift_pkg::DFLT_WIDTH
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [1:0]       i_code,
    output logic [WIDTH-1:0] o_data
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic w_from_lo;   // source for a left shift
            logic w_from_hi;   // source for a right shift

            if (gi == 0) begin : g_lo_edge
                assign w_from_lo = 1'b0;
            end else begin : g_lo_mid
                assign w_from_lo = i_data[gi-1];
            end

            if (gi == WIDTH-1) begin : g_hi_edge
                // MSB fill: 0 for logical right, 1 for the fill-one variant
                assign w_from_hi = (i_code == SH_RS1);
            end else begin : g_hi_mid
                assign w_from_hi = i_data[gi+1];
            end

            // Per-bit source select
            always_comb begin
                case (i_code)
                    SH_LSL:          o_data[gi] = w_from_lo;
                    SH_LSR, SH_RS1:  o_data[gi] = w_from_hi;
                    default:         o_data[gi] = i_data[gi];
                endcase
            end
        end
    endgenerate

endmodule

// File: rtl/shift_sequencer.sv
// Iterative multi-bit shift engine: captures an operand, applies one
// single-bit step per clock and presents the result with a done pulse.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = shift_pkg::DFLT_WIDTH,
    parameter int AMT_W = shift_pkg::DFLT_AMT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_in,
    input  logic [1:0]       i_shift,
    input  logic [AMT_W-1:0] i_amount,
    output logic             o_ready,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sout
);

    seq_state_t       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_acc,   w_acc_nxt;
    logic [AMT_W-1:0] r_rem,   w_rem_nxt;
    logic [1:0]       r_code,  w_code_nxt;
    logic [WIDTH-1:0] r_sout,  w_sout_nxt;
    logic [WIDTH-1:0] w_step;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .i_data (r_acc),
        .i_code (r_code),
        .o_data (w_step)
    );

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_rem   <= '0;
            r_code  <= SH_PASS;
            r_sout  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_rem   <= w_rem_nxt;
            r_code  <= w_code_nxt;
            r_sout  <= w_sout_nxt;
        end
    end

    // Next-state and datapath updates; sout only moves on entry to DONE
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_rem_nxt   = r_rem;
        w_code_nxt  = r_code;
        w_sout_nxt  = r_sout;
        case (r_state)
            IDLE, DONE: begin
                if (i_start) begin
                    w_acc_nxt  = i_in;
                    w_code_nxt = i_shift;
                    w_rem_nxt  = i_amount;
                    if (i_amount == '0 || i_shift == SH_PASS) begin
                        // Nothing to iterate: result is the operand itself
                        w_sout_nxt  = i_in;
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                // start is ignored here; the captured operation runs to completion
                w_acc_nxt = w_step;
                w_rem_nxt = r_rem - AMT_W'(1);
                if (r_rem == AMT_W'(1)) begin
                    w_sout_nxt  = w_step;
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_ready = (r_state != RUN);
    assign o_done  = (r_state == DONE);
    assign o_sout  = r_sout;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and randomized bench for shift_sequencer, checked against an
// arithmetic reference of multi-bit shifts and cycle-exact latency.
module tb_shift_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] din;
    logic [1:0]  shift;
    logic [3:0]  amount;
    logic        ready;
    logic        done;
    logic [15:0] sout;

    int errors = 0;
    int checks = 0;
    logic [15:0] model_sout = 16'h0000;

    shift_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (start),
        .i_in     (din),
        .i_shift  (shift),
        .i_amount (amount),
        .o_ready  (ready),
        .o_done   (done),
        .o_sout   (sout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result: a multi-bit shift expressed directly in arithmetic
    function automatic logic [15:0] ref_shift(input logic [15:0] v, input logic [1:0] sh,
                                              input logic [3:0] n);
        logic [15:0] ones;
        ones = 16'hFFFF;
        case (sh)
            2'b01:   ref_shift = v << n;
            2'b10:   ref_shift = v >> n;
            2'b11:   ref_shift = (v >> n) | ~(ones >> n);
            default: ref_shift = v;
        endcase
    endfunction

    // Called at a negedge. Issues one operation, checks busy cycles and the
    // done cycle, and returns at the negedge inside the done cycle.
    // junk_at >= 0 pulses a spurious start at that busy-cycle index.
    task automatic op(input logic [15:0] v, input logic [1:0] sh, input logic [3:0] n,
                      input int junk_at, input string tag);
        int busy;
        logic [15:0] expv;
        expv = ref_shift(v, sh, n);
        busy = (n == 0 || sh == 2'b00) ? 0 : int'(n);
        start = 1'b1; din = v; shift = sh; amount = n;
        @(negedge clk);
        start = 1'b0; din = $urandom; shift = 2'($urandom); amount = 4'($urandom);
        for (int k = 0; k < busy; k++) begin
            if (k == 0 || k == busy-1 || k == junk_at) begin
                chk({tag, " busy ready"}, 32'(ready), 32'd0);
                chk({tag, " busy done"},  32'(done),  32'd0);
                chk({tag, " busy sout held"}, 32'(sout), 32'(model_sout));
            end
            start = (k == junk_at);
            if (k == junk_at) begin
                din = 16'h5A5A; shift = 2'b01; amount = 4'd1;
            end
            @(negedge clk);
            start = 1'b0;
        end
        model_sout = expv;
        chk({tag, " done"},  32'(done),  32'd1);
        chk({tag, " ready"}, 32'(ready), 32'd1);
        chk({tag, " sout"},  32'(sout),  32'(expv));
    endtask

    // One idle cycle after a done: pulse must have ended, result held
    task automatic idle(input string tag);
        start = 1'b0;
        @(negedge clk);
        chk({tag, " idle done"},  32'(done),  32'd0);
        chk({tag, " idle ready"}, 32'(ready), 32'd1);
        chk({tag, " idle sout"},  32'(sout),  32'(model_sout));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; din = '0; shift = '0; amount = '0;
        repeat (2) @(negedge clk);
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset done",  32'(done),  32'd0);
        chk("reset sout",  32'(sout),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        op(16'h8001, 2'b01, 4'd1,  -1, "lsl1");       idle("lsl1");
        op(16'hF0F0, 2'b10, 4'd4,  -1, "lsr4");       idle("lsr4");
        op(16'h0001, 2'b01, 4'd15, -1, "lsl15");      idle("lsl15");
        op(16'h0008, 2'b11, 4'd3,  -1, "rs1x3");      idle("rs1x3");
        op(16'h1234, 2'b00, 4'd15, -1, "pass");       idle("pass");
        op(16'h1234, 2'b01, 4'd0,  -1, "amt0");       idle("amt0");
        chk("const lsl1", 32'(ref_shift(16'h8001, 2'b01, 4'd1)), 32'h0002);
        chk("const rs1",  32'(ref_shift(16'h0008, 2'b11, 4'd3)), 32'hE001);

        // Spurious start mid-run, then a back-to-back start in the done cycle
        op(16'hFFFF, 2'b10, 4'd8, 2, "ignore");
        op(16'hA5A5, 2'b11, 4'd2, -1, "b2b");
        op(16'h00FF, 2'b00, 4'd3, -1, "b2b0");
        op(16'h0F00, 2'b01, 4'd0, -1, "b2b00");
        idle("b2b");

        // Reset in the middle of a run
        start = 1'b1; din = 16'hBEEF; shift = 2'b01; amount = 4'd15;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre-reset ready", 32'(ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid reset ready", 32'(ready), 32'd1);
        chk("mid reset done",  32'(done),  32'd0);
        chk("mid reset sout",  32'(sout),  32'd0);
        model_sout = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int late;
            late = 0;
            repeat (20) begin
                @(negedge clk);
                if (done) late++;
            end
            chk("no late done", 32'(late), 32'd0);
        end

        // Randomized operations with random gaps
        for (int t = 0; t < 40; t++) begin
            op(16'($urandom), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), -1, "rand");
            if ($urandom_range(0, 1) == 1) idle("rand");
        end
        idle("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
